// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: requester-side and memory-side bundle of the dmem arbiter.
// slave = arbiter view, master = requesters/memory view.
interface dmem_arbiter_if #(
  parameter int NBITS_O = 11,
  parameter int NBITS_D = 16
) ();
  logic               i_req0;
  logic               i_wr0;
  logic [NBITS_O-1:0] i_addr0;
  logic [NBITS_D-1:0] i_wdata0;
  logic               o_ack0;
  logic               o_err0;
  logic [NBITS_D-1:0] o_rdata0;
  logic               i_req1;
  logic               i_wr1;
  logic [NBITS_O-1:0] i_addr1;
  logic [NBITS_D-1:0] i_wdata1;
  logic               o_ack1;
  logic               o_err1;
  logic [NBITS_D-1:0] o_rdata1;
  logic               o_mem_Rd;
  logic               o_mem_Wr;
  logic [NBITS_O-1:0] o_mem_Addr;
  logic [NBITS_D-1:0] o_mem_InData;
  logic [NBITS_D-1:0] i_mem_OutData;
  logic               o_busy;

  modport slave (
    input  i_req0, i_wr0, i_addr0, i_wdata0,
    input  i_req1, i_wr1, i_addr1, i_wdata1,
    input  i_mem_OutData,
    output o_ack0, o_err0, o_rdata0,
    output o_ack1, o_err1, o_rdata1,
    output o_mem_Rd, o_mem_Wr, o_mem_Addr,
    output o_mem_InData, o_busy
  );

  modport master (
    output i_req0, i_wr0, i_addr0, i_wdata0,
    output i_req1, i_wr1, i_addr1, i_wdata1,
    output i_mem_OutData,
    input  o_ack0, o_err0, o_rdata0,
    input  o_ack1, o_err1, o_rdata1,
    input  o_mem_Rd, o_mem_Wr, o_mem_Addr,
    input  o_mem_InData, o_busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port sequencer for the single-port data memory.
// DMEM_ARB_RR_EN selects round-robin tie break (default: port 0 priority).
module dmem_arbiter #(
  parameter int NBITS_O = 11,
  parameter int NBITS_D = 16,
  parameter int CELDAS  = 10
) (
  input logic           i_clk,
  input logic           i_reset,
  dmem_arbiter_if.slave bus
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam logic [NBITS_O-1:0] LIM = NBITS_O'(CELDAS);

  state_t             state_q, state_d;
  logic               sel_q, sel_d;
  logic               err_q, err_d;
  logic               rd_q, rd_d;
  logic               wr_q, wr_d;
  logic [NBITS_O-1:0] addr_q, addr_d;
  logic [NBITS_D-1:0] wdata_q, wdata_d;
  logic               ack0_q, ack0_d;
  logic               ack1_q, ack1_d;
  logic               err0_q, err0_d;
  logic               err1_q, err1_d;
  logic [NBITS_D-1:0] rdata0_q, rdata0_d;
  logic [NBITS_D-1:0] rdata1_q, rdata1_d;

  logic               any_req;
  logic               win;
  logic               g_wr;
  logic [NBITS_O-1:0] g_addr;
  logic [NBITS_D-1:0] g_wdata;
  logic               g_ok;

  assign any_req = bus.i_req0 | bus.i_req1;

`ifdef DMEM_ARB_RR_EN
  logic last_q, last_d;
  // tie goes to the port not granted last
  assign win = bus.i_req1 & (~bus.i_req0 | ~last_q);
`else
  assign win = ~bus.i_req0;
`endif

  assign g_wr    = win ? bus.i_wr1    : bus.i_wr0;
  assign g_addr  = win ? bus.i_addr1  : bus.i_addr0;
  assign g_wdata = win ? bus.i_wdata1 : bus.i_wdata0;
  assign g_ok    = g_addr < LIM;

  // grant in IDLE, complete and ack in ACCESS
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    err_d    = err_q;
    rd_d     = 1'b0;
    wr_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    err0_d   = 1'b0;
    err1_d   = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
`ifdef DMEM_ARB_RR_EN
    last_d   = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = ACCESS;
          sel_d   = win;
          addr_d  = g_addr;
          wdata_d = g_wdata;
          err_d   = ~g_ok;
          wr_d    = g_ok & g_wr;
          rd_d    = g_ok & ~g_wr;
`ifdef DMEM_ARB_RR_EN
          last_d  = win;
`endif
        end
      end
      ACCESS: begin
        state_d = IDLE;
        if (sel_q) begin
          ack1_d = 1'b1;
          err1_d = err_q;
          if (err_q)
            rdata1_d = '0;
          else if (rd_q)
            rdata1_d = bus.i_mem_OutData;
        end else begin
          ack0_d = 1'b1;
          err0_d = err_q;
          if (err_q)
            rdata0_d = '0;
          else if (rd_q)
            rdata0_d = bus.i_mem_OutData;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and output registers
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= IDLE;
      sel_q    <= 1'b0;
      err_q    <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
`ifdef DMEM_ARB_RR_EN
      last_q   <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      err_q    <= err_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
`ifdef DMEM_ARB_RR_EN
      last_q   <= last_d;
`endif
    end
  end

  assign bus.o_ack0       = ack0_q;
  assign bus.o_err0       = err0_q;
  assign bus.o_rdata0     = rdata0_q;
  assign bus.o_ack1       = ack1_q;
  assign bus.o_err1       = err1_q;
  assign bus.o_rdata1     = rdata1_q;
  assign bus.o_mem_Rd     = rd_q;
  assign bus.o_mem_Wr     = wr_q;
  assign bus.o_mem_Addr   = addr_q;
  assign bus.o_mem_InData = wdata_q;
  assign bus.o_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench with a negedge data memory model.
// Build with DMEM_ARB_RR_EN to check the round-robin tie break.
module tb_dmem_arbiter;

  logic clk;
  logic rst_n;

  dmem_arbiter_if #(.NBITS_O(11), .NBITS_D(16)) bus ();

  dmem_arbiter #(
    .NBITS_O(11),
    .NBITS_D(16),
    .CELDAS (10)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] mem [0:9];

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 10; i++)
        mem[i] <= 16'(i);
      bus.i_mem_OutData <= 16'h0;
    end else begin
      if (bus.o_mem_Wr && bus.o_mem_Addr < 11'd10)
        mem[bus.o_mem_Addr[3:0]] <= bus.o_mem_InData;
      if (bus.o_mem_Rd && bus.o_mem_Addr < 11'd10)
        bus.i_mem_OutData <= mem[bus.o_mem_Addr[3:0]];
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  logic        r_ack, r_err, r_oth, r_busy;
  logic [15:0] r_rd;
  logic [10:0] r_aseen;
  int          r_lat, r_nrd, r_nwr;

  task automatic rst_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic acc(input bit p, input logic w,
                     input logic [10:0] a,
                     input logic [15:0] d,
                     input bit chg);
    int n;
    @(negedge clk);
    if (!p) begin
      bus.i_req0 = 1'b1; bus.i_wr0 = w;
      bus.i_addr0 = a; bus.i_wdata0 = d;
    end else begin
      bus.i_req1 = 1'b1; bus.i_wr1 = w;
      bus.i_addr1 = a; bus.i_wdata1 = d;
    end
    n = 0; r_ack = 0; r_err = 0; r_oth = 0;
    r_busy = 0; r_rd = '0; r_aseen = '0;
    r_lat = 0; r_nrd = 0; r_nwr = 0;
    while (!r_ack && n < 8) begin
      @(negedge clk);
      n++;
      if (bus.o_mem_Rd) r_nrd++;
      if (bus.o_mem_Wr) r_nwr++;
      if (n == 1) begin
        r_aseen = bus.o_mem_Addr;
        r_busy  = bus.o_busy;
        if (chg) bus.i_addr0 = 11'd7;
      end
      if (p ? bus.o_ack0 : bus.o_ack1) r_oth = 1;
      if (p ? bus.o_ack1 : bus.o_ack0) begin
        r_ack = 1;
        r_lat = n;
        r_rd  = p ? bus.o_rdata1 : bus.o_rdata0;
        r_err = p ? bus.o_err1 : bus.o_err0;
      end
    end
    bus.i_req0 = 1'b0;
    bus.i_req1 = 1'b0;
    chk("ack_seen", r_ack, 1);
  endtask

  int       n0, n1, nb, na;
  bit       seen;
  bit [7:0] seq;

  initial begin
    rst_n = 1'b0;
    bus.i_req0 = 0; bus.i_wr0 = 0;
    bus.i_addr0 = 0; bus.i_wdata0 = 0;
    bus.i_req1 = 0; bus.i_wr1 = 0;
    bus.i_addr1 = 0; bus.i_wdata1 = 0;
    repeat (2) @(negedge clk);
    chk("rst_ack0", bus.o_ack0, 0);
    chk("rst_err0", bus.o_err0, 0);
    chk("rst_rdata0", bus.o_rdata0, 0);
    chk("rst_ack1", bus.o_ack1, 0);
    chk("rst_err1", bus.o_err1, 0);
    chk("rst_rdata1", bus.o_rdata1, 0);
    chk("rst_rd", bus.o_mem_Rd, 0);
    chk("rst_wr", bus.o_mem_Wr, 0);
    chk("rst_addr", bus.o_mem_Addr, 0);
    chk("rst_indata", bus.o_mem_InData, 0);
    chk("rst_busy", bus.o_busy, 0);
    rst_n = 1'b1;

    // reset while an access is in flight
    @(negedge clk);
    bus.i_req0 = 1; bus.i_wr0 = 0; bus.i_addr0 = 11'd2;
    @(negedge clk);
    chk("t1_busy_acc", bus.o_busy, 1);
    chk("t1_rd_acc", bus.o_mem_Rd, 1);
    chk("t1_addr_acc", bus.o_mem_Addr, 2);
    #1 rst_n = 1'b0;
    #1;
    chk("t1_busy_rst", bus.o_busy, 0);
    chk("t1_rd_rst", bus.o_mem_Rd, 0);
    chk("t1_addr_rst", bus.o_mem_Addr, 0);
    chk("t1_ack_rst", bus.o_ack0, 0);
    bus.i_req0 = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.o_ack0 || bus.o_ack1) seen = 1;
    end
    chk("t1_no_ack", seen, 0);
    chk("t1_idle", bus.o_busy, 0);

    // port 0 write then read back
    acc(0, 1, 11'd3, 16'hBEEF, 0);
    chk("t2w_lat", r_lat, 2);
    chk("t2w_busy", r_busy, 1);
    chk("t2w_wr_pulse", r_nwr, 1);
    chk("t2w_no_rd", r_nrd, 0);
    chk("t2w_err", r_err, 0);
    chk("t2w_rdata_held", r_rd, 0);
    chk("t2w_oth", r_oth, 0);
    acc(0, 0, 11'd3, 16'h0, 0);
    chk("t2r_lat", r_lat, 2);
    chk("t2r_rd_pulse", r_nrd, 1);
    chk("t2r_no_wr", r_nwr, 0);
    chk("t2r_rdata", r_rd, 16'hBEEF);
    chk("t2r_err", r_err, 0);

    // port 1 last valid cell and first invalid one
    rst_pulse();
    acc(1, 0, 11'd9, 16'h0, 0);
    chk("t3a_rdata", r_rd, 16'h0009);
    chk("t3a_err", r_err, 0);
    chk("t3a_oth", r_oth, 0);
    acc(1, 0, 11'd10, 16'h0, 0);
    chk("t3b_err", r_err, 1);
    chk("t3b_rdata", r_rd, 0);
    chk("t3b_no_rd", r_nrd, 0);
    chk("t3b_lat", r_lat, 2);
    acc(0, 1, 11'h7FF, 16'h1234, 0);
    chk("t3c_err", r_err, 1);
    chk("t3c_no_wr", r_nwr, 0);
    chk("t3c_rdata", r_rd, 0);

    // continuous contention for 8 edges
    rst_pulse();
    @(negedge clk);
    bus.i_req0 = 1; bus.i_wr0 = 0; bus.i_addr0 = 11'd1;
    bus.i_req1 = 1; bus.i_wr1 = 0; bus.i_addr1 = 11'd2;
    n0 = 0; n1 = 0; nb = 0; na = 0; seq = '0;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (bus.o_ack0 && bus.o_ack1) nb++;
      if (bus.o_ack0 || bus.o_ack1) begin
        if (na < 8) seq[na] = bus.o_ack1;
        na++;
      end
      if (bus.o_ack0) n0++;
      if (bus.o_ack1) n1++;
      if (k == 8) begin
        bus.i_req0 = 0;
        bus.i_req1 = 0;
      end
    end
    chk("t4_both", nb, 0);
    chk("t4_total", na, 4);
`ifdef DMEM_ARB_RR_EN
    chk("t5_n0", n0, 2);
    chk("t5_n1", n1, 2);
    chk("t5_seq", seq, 8'h0A);
    chk("t5_rdata1", bus.o_rdata1, 16'h0002);
`else
    chk("t4_n0", n0, 4);
    chk("t4_n1", n1, 0);
    chk("t4_seq", seq, 8'h00);
    chk("t4_rdata1", bus.o_rdata1, 16'h0000);
`endif
    chk("t4_rdata0", bus.o_rdata0, 16'h0001);

    // address change during ACCESS must not reach memory
    acc(0, 0, 11'd5, 16'h0, 1);
    chk("t6_addr", r_aseen, 5);
    chk("t6_rdata", r_rd, 16'h0005);
    chk("t6_err", r_err, 0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
